// File: rtl/bitop_pkg.sv
// Shared definitions for the bit-op scheduler: opcodes, FSM states, count width.
package bitop_pkg;

  localparam int BITOP_W = 32;
  localparam int CNT_W   = $clog2(BITOP_W) + 1;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_CLZ  = 3'd4;
  localparam logic [2:0] OP_CTZ  = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_CLZ) || (op == OP_CTZ) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/bitop_count_iter.sv
// Iterative CLZ/CTZ/POP: one CHUNK per step, CLZ walks from the MSB chunk down.
// o_count is the running total including the chunk selected this cycle.
module bitop_count_iter
  import bitop_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int NCH   = WIDTH / CHUNK,
  parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [IDX_W-1:0] i_idx,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_acc;
  logic             r_found;
  logic [IDX_W-1:0] w_sel;
  logic [CHUNK-1:0] w_chunk;
  logic [CNT_W-1:0] w_lz;
  logic [CNT_W-1:0] w_tz;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] w_add;
  logic             w_hit_l;
  logic             w_hit_t;

  assign w_sel = (i_op == OP_CLZ) ? (IDX_W'(NCH - 1) - i_idx) : i_idx;

  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sel == IDX_W'(i)) w_chunk = i_a[i*CHUNK +: CHUNK];
    end
  end

  // An all-zero chunk yields lz == tz == CHUNK, so no separate zero case.
  always_comb begin
    w_lz    = '0;
    w_tz    = '0;
    w_pop   = '0;
    w_hit_l = 1'b0;
    w_hit_t = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (w_chunk[i]) w_hit_l = 1'b1;
      else if (!w_hit_l) w_lz = w_lz + CNT_W'(1);
    end
    for (int i = 0; i < CHUNK; i++) begin
      if (w_chunk[i]) w_hit_t = 1'b1;
      else if (!w_hit_t) w_tz = w_tz + CNT_W'(1);
      w_pop = w_pop + CNT_W'(w_chunk[i]);
    end
  end

  always_comb begin
    w_add = '0;
    if (i_op == OP_POP) w_add = w_pop;
    else if (!r_found) w_add = (i_op == OP_CLZ) ? w_lz : w_tz;
  end

  assign o_count = r_acc + w_add;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc   <= '0;
      r_found <= 1'b0;
    end else if (i_step) begin
      r_acc   <= o_count;
      r_found <= r_found | (|w_chunk);
    end
  end

endmodule

// File: rtl/bitop_sched.sv
// Two-requester round-robin front end for a shared 32-bit bit-logic unit.
// Logic ops answer one cycle after accept; count ops take WIDTH/CHUNK more.
module bitop_sched
  import bitop_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_id;
  logic             r_rr;

  logic             w_accept;
  logic             w_gnt_id;
  logic             w_last;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_logic_res;
  logic [CNT_W-1:0] w_count;

  assign w_gnt_id = (req0_valid && req1_valid) ? r_rr : req1_valid;
  assign w_sel_op = w_gnt_id ? req1_op : req0_op;
  assign w_sel_a  = w_gnt_id ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt_id ? req1_b  : req0_b;
  assign w_last   = (r_cnt == IDX_W'(NCH - 1));

  always_comb begin
    w_logic_res = '0;
    case (w_sel_op)
      OP_NOT:  w_logic_res = ~w_sel_a;
      OP_AND:  w_logic_res = w_sel_a & w_sel_b;
      OP_OR:   w_logic_res = w_sel_a | w_sel_b;
      OP_XOR:  w_logic_res = w_sel_a ^ w_sel_b;
      OP_RSVD: w_logic_res = '0;
      default: w_logic_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Readies are gated by rst so nothing is accepted on a reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          w_accept    = 1'b1;
          req0_ready  = !w_gnt_id;
          req1_ready  = w_gnt_id;
          w_state_nxt = is_count_op(w_sel_op) ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (res_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_op       <= OP_NOT;
      r_a        <= '0;
      r_res_data <= '0;
      r_res_id   <= 1'b0;
      r_rr       <= 1'b0;
    end else if (w_accept) begin
      r_op     <= w_sel_op;
      r_a      <= w_sel_a;
      r_cnt    <= '0;
      r_res_id <= w_gnt_id;
      r_rr     <= ~w_gnt_id;
      if (!is_count_op(w_sel_op)) r_res_data <= w_logic_res;
    end else if (r_state == ST_EXEC) begin
      r_cnt <= r_cnt + IDX_W'(1);
      if (w_last) r_res_data <= WIDTH'(w_count);
    end
  end

  bitop_count_iter #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) u_count (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_accept),
    .i_step (r_state == ST_EXEC),
    .i_op   (r_op),
    .i_a    (r_a),
    .i_idx  (r_cnt),
    .o_count(w_count)
  );

  assign res_valid = (r_state == ST_DONE);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_bitop_sched.sv
// Bench for bitop_sched: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of grant, latency and result.
module tb_bitop_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        res_valid, res_id;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;

  bitop_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int n;
    n = 0;
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: begin
        while (n < 32 && !a[31-n]) n++;
        return n;
      end
      3'd5: begin
        while (n < 32 && !a[n]) n++;
        return n;
      end
      3'd6: return $countones(a);
      default: return 32'd0;
    endcase
  endfunction

  // Model: at most one op outstanding; its answer is due a fixed number of cycles after accept.
  bit          m_pend = 0;
  int          m_due = 0;
  logic [31:0] m_data = '0;
  logic        m_id = 1'b0, m_rr = 1'b0;
  bit          hs0 = 0, hs1 = 0;
  int          gq[$];

  always @(negedge clk) begin : monitor
    logic       any, g;
    logic [2:0] op;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (hs0) gq.push_back(0);
    if (hs1) gq.push_back(1);
    if (rst) begin
      check("rst_rdy0", req0_ready, 0);
      check("rst_rdy1", req1_ready, 0);
      m_pend = 0;
      m_rr   = 1'b0;
    end else begin
      any = !m_pend && (req0_valid || req1_valid);
      g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
      check("rdy0", req0_ready, any && !g);
      check("rdy1", req1_ready, any && g);
      check("res_valid", res_valid, m_pend && cyc >= m_due);
      if (m_pend && cyc >= m_due) begin
        check("res_data", res_data, m_data);
        check("res_id", res_id, m_id);
        if (res_ready) m_pend = 0;
      end
      if (any) begin
        op     = g ? req1_op : req0_op;
        m_data = ref_result(op, g ? req1_a : req0_a, g ? req1_b : req0_b);
        m_id   = g;
        m_rr   = !g;
        m_due  = cyc + ((op >= 3'd4 && op <= 3'd6) ? 1 + 32 / 8 : 1);
        m_pend = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int t);
    bit done;
    done = 0;
    t = -1;
    drive(r, 1'b1, op, a, b);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
        done = 1;
        t = cyc;
      end
      tick();
    end
    drive(r, 1'b0, op, a, b);
    if (!done) check("issue_timeout", 0, 1);
  endtask

  task automatic get_result(output logic [31:0] d, output logic id, output int t);
    bit done;
    done = 0;
    t = -1; d = '0; id = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (res_valid) begin
        done = 1; d = res_data; id = res_id; t = cyc;
      end
    end
    tick();
    if (!done) check("result_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 4)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1 << ($urandom % 32);
      default: return $urandom;
    endcase
  endfunction

  // Holds each op until it is handshaken, then picks a fresh one (or idles).
  task automatic rand_drive(input int r, input int n);
    logic v; logic [2:0] op; logic [31:0] a, b;
    v = 1'b0; op = 3'd0; a = '0; b = '0;
    for (int k = 0; k < n; k++) begin
      if (!v || (r == 0 ? hs0 : hs1)) begin
        v = ($urandom % 3) != 0;
        op = 3'($urandom % 8);
        a = rand_word();
        b = $urandom;
      end
      drive(r, v, op, a, b);
      tick();
    end
    drive(r, 1'b0, 3'd0, '0, '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1, ta, tb, r0, r1;
    logic [31:0] d0, d1;
    logic id0, id1;
    logic [2:0]  t3_op  [3] = '{3'd5, 3'd4, 3'd5};
    logic [31:0] t3_a   [3] = '{32'h0, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] t3_exp [3] = '{32'd32, 32'd0, 32'd16};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_res_id", res_id, 0);
    check("reset_rdy0", req0_ready, 0);
    check("reset_rdy1", req1_ready, 0);
    tick();

    // Single logic op, one-cycle latency.
    issue(0, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, t0);
    get_result(d0, id0, t1);
    check("t1_data", d0, 32'hF000_F000);
    check("t1_id", id0, 0);
    check("t1_lat", t1 - t0, 1);

    // Both requesters valid straight after reset: req0 wins, then req1.
    do_reset();
    fork
      issue(0, 3'd6, 32'hFFFF_FFFF, 32'h0, ta);
      issue(1, 3'd4, 32'h0000_0001, 32'h0, tb);
      begin
        get_result(d0, id0, r0);
        get_result(d1, id1, r1);
      end
    join
    check("t2_pop", d0, 32);
    check("t2_id0", id0, 0);
    check("t2_lat0", r0 - ta, 5);
    check("t2_clz", d1, 31);
    check("t2_id1", id1, 1);
    check("t2_lat1", r1 - tb, 5);
    check("t2_order", ta < tb, 1);

    for (int i = 0; i < 3; i++) begin
      issue(0, t3_op[i], t3_a[i], 32'h0, t0);
      get_result(d0, id0, t1);
      check("t3_data", d0, t3_exp[i]);
      check("t3_lat", t1 - t0, 5);
    end

    // Consumer stalls in DONE while req0 waits.
    res_ready = 1'b0;
    issue(1, 3'd3, 32'hA5A5_A5A5, 32'hFFFF_0000, t0);
    get_result(d0, id0, t1);
    drive(0, 1'b1, 3'd0, 32'h1234_5678, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_data", res_data, 32'h5A5A_A5A5);
      check("t4_hold_id", res_id, 1);
      check("t4_hold_rdy0", req0_ready, 0);
      check("t4_hold_rdy1", req1_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", res_valid, 1);
    tick();
    @(negedge clk);
    check("t4_accept_next", req0_ready, 1);
    tick();
    drive(0, 1'b0, 3'd0, '0, '0);
    get_result(d0, id0, t1);
    check("t4_next_data", d0, 32'hEDCB_A987);

    // Reset in the middle of a POP drops it and clears the rr pointer.
    issue(0, 3'd6, 32'hDEAD_BEEF, 32'h0, t0);
    tick();
    do_reset();
    @(negedge clk);
    check("t5_res_valid", res_valid, 0);
    check("t5_res_data", res_data, 0);
    check("t5_res_id", res_id, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_res", res_valid, 0);
      tick();
    end
    fork
      issue(0, 3'd0, 32'h0F0F_0F0F, 32'h0, ta);
      issue(1, 3'd0, 32'h3333_3333, 32'h0, tb);
    join
    check("t5_rr_reset", ta < tb, 1);
    repeat (4) tick();

    // Random traffic with a randomly stalling consumer.
    fork
      rand_drive(0, 400);
      rand_drive(1, 400);
      begin
        for (int k = 0; k < 400; k++) begin
          res_ready = ($urandom % 4) != 0;
          tick();
        end
        res_ready = 1'b1;
      end
    join
    repeat (20) tick();

    // Continuous both-valid stream after reset alternates 0,1,0,1.
    do_reset();
    gq.delete();
    drive(0, 1'b1, 3'd1, 32'hCAFE_F00D, 32'h00FF_00FF);
    drive(1, 1'b1, 3'd2, 32'h1234_0000, 32'h0000_5678);
    repeat (12) tick();
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 3'd0, '0, '0);
    repeat (4) tick();
    check("t6_ngrants", gq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) check("t6_alternate", gq[i], i % 2);

    // Reserved opcode yields zero in one cycle.
    issue(0, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
    get_result(d0, id0, t1);
    check("t6_rsvd_data", d0, 0);
    check("t6_rsvd_lat", t1 - t0, 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
